// File: rtl/serial_twos_comp_array.sv
// rtl/serial_twos_comp_array.sv - bit-serial two's-complement negator, CHANNELS lanes, shared framing
//
// Purpose:
//   Each lane receives a WIDTH-bit word LSB-first and emits either its
//   two's-complement negation or an unchanged copy. Negation copies bits up to
//   and including the first 1, then inverts the remaining bits. All lanes
//   share one valid strobe, one bit counter and one per-word mode.
//   Output latency is exactly one cycle.
//
// Ports:
//   t_clk      in   1         clock, rising edge
//   r          in   1         synchronous active-high reset
//   in_valid   in   1         bit beat present on in_bits
//   in_bits    in   CHANNELS  serial data, bit c = lane c, LSB first
//   neg_en     in   1         1 = negate, 0 = pass; sampled on bit-0 beat only
//   out_valid  out  1         registered in_valid
//   out_bits   out  CHANNELS  converted serial data, 0 when out_valid = 0
//   out_first  out  1         beat carries bit 0 of a word
//   out_last   out  1         beat carries bit WIDTH-1 of a word
//   ovf        out  CHANNELS  negation of most-negative value, only with out_last

module serial_twos_comp_array #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 1
) (
  input  logic                t_clk,
  input  logic                r,
  input  logic                in_valid,
  input  logic [CHANNELS-1:0] in_bits,
  input  logic                neg_en,
  output logic                out_valid,
  output logic [CHANNELS-1:0] out_bits,
  output logic                out_first,
  output logic                out_last,
  output logic [CHANNELS-1:0] ovf
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]       cnt_q;
  logic [CHANNELS-1:0] flip_q;
  logic                mode_q;

  logic                first_beat;
  logic                last_beat;
  logic                mode_cur;
  logic [CHANNELS-1:0] flip_cur;
  logic [CHANNELS-1:0] conv_bits;
  logic [CHANNELS-1:0] flip_nxt;
  logic [CHANNELS-1:0] ovf_nxt;
  logic [CW-1:0]       cnt_nxt;

  always_comb begin
    first_beat = (cnt_q == '0);
    last_beat  = (cnt_q == CNT_LAST);
    // Mode is latched on the bit-0 beat and held for the rest of the word.
    mode_cur   = first_beat ? neg_en : mode_q;
    // A new word never inherits flip state, even if the previous word was cut short.
    flip_cur   = first_beat ? '0 : flip_q;
    conv_bits  = in_bits ^ ({CHANNELS{mode_cur}} & flip_cur);
    flip_nxt   = last_beat ? '0 : (flip_cur | in_bits);
    // Only 1000..0 reaches the MSB with flip clear and a 1 on the wire.
    ovf_nxt    = last_beat ? ({CHANNELS{mode_cur}} & in_bits & ~flip_cur) : '0;
    cnt_nxt    = last_beat ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge t_clk) begin
    if (r) begin
      out_valid <= 1'b0;
      out_bits  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      ovf       <= '0;
      cnt_q     <= '0;
      flip_q    <= '0;
      mode_q    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_bits  <= conv_bits;
        out_first <= first_beat;
        out_last  <= last_beat;
        ovf       <= ovf_nxt;
        cnt_q     <= cnt_nxt;
        flip_q    <= flip_nxt;
        mode_q    <= mode_cur;
      end else begin
        out_bits  <= '0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
        ovf       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_serial_twos_comp_array.sv
// tb/tb_serial_twos_comp_array.sv - scoreboard bench for serial_twos_comp_array

module tb_serial_twos_comp_array;

  typedef struct packed {
    logic [2:0] bits;
    logic       first;
    logic       last;
    logic [2:0] ovf;
  } exp_t;

  logic clk;
  int   n_tests;
  int   n_fail;
  logic mon_en;

  exp_t q_a[$];
  exp_t q_b[$];

  // instance A: WIDTH=4, CHANNELS=2
  logic       r_a, a_in_valid, a_neg_en;
  logic [1:0] a_in_bits;
  logic       a_out_valid, a_out_first, a_out_last;
  logic [1:0] a_out_bits, a_ovf;

  // instance B: WIDTH=8, CHANNELS=3
  logic       r_b, b_in_valid, b_neg_en;
  logic [2:0] b_in_bits;
  logic       b_out_valid, b_out_first, b_out_last;
  logic [2:0] b_out_bits, b_ovf;

  serial_twos_comp_array #(.WIDTH(4), .CHANNELS(2)) dut_a (
    .t_clk(clk), .r(r_a), .in_valid(a_in_valid), .in_bits(a_in_bits), .neg_en(a_neg_en),
    .out_valid(a_out_valid), .out_bits(a_out_bits), .out_first(a_out_first),
    .out_last(a_out_last), .ovf(a_ovf)
  );

  serial_twos_comp_array #(.WIDTH(8), .CHANNELS(3)) dut_b (
    .t_clk(clk), .r(r_b), .in_valid(b_in_valid), .in_bits(b_in_bits), .neg_en(b_neg_en),
    .out_valid(b_out_valid), .out_bits(b_out_bits), .out_first(b_out_first),
    .out_last(b_out_last), .ovf(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitors: pop on every valid output beat, require all-zero outputs otherwise
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_out_valid) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_beat", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q_a.pop_front();
          chk("a_bits",  {30'd0, a_out_bits}, {29'd0, e.bits});
          chk("a_first", {31'd0, a_out_first}, {31'd0, e.first});
          chk("a_last",  {31'd0, a_out_last},  {31'd0, e.last});
          chk("a_ovf",   {30'd0, a_ovf},       {29'd0, e.ovf});
        end
      end else begin
        chk("a_idle_outputs", {26'd0, a_out_bits, a_out_first, a_out_last, a_ovf}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (b_out_valid) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_beat", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q_b.pop_front();
          chk("b_bits",  {29'd0, b_out_bits}, {29'd0, e.bits});
          chk("b_first", {31'd0, b_out_first}, {31'd0, e.first});
          chk("b_last",  {31'd0, b_out_last},  {31'd0, e.last});
          chk("b_ovf",   {29'd0, b_ovf},       {29'd0, e.ovf});
        end
      end else begin
        chk("b_idle_outputs", {24'd0, b_out_bits, b_out_first, b_out_last, b_ovf}, 32'd0);
      end
    end
  end

  task automatic a_beat(input logic [1:0] b, input logic n, input logic [1:0] eb,
                        input logic ef, input logic el, input logic [1:0] eo);
    exp_t e;
    @(negedge clk);
    r_a = 1'b0; a_in_valid = 1'b1; a_in_bits = b; a_neg_en = n;
    e.bits = {1'b0, eb}; e.first = ef; e.last = el; e.ovf = {1'b0, eo};
    q_a.push_back(e);
  endtask

  task automatic a_idle(input int n, input logic [1:0] junk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      r_a = 1'b0; a_in_valid = 1'b0; a_in_bits = junk; a_neg_en = 1'b0;
    end
  endtask

  task automatic b_beat(input logic [2:0] b, input logic n, input logic [2:0] eb,
                        input logic ef, input logic el, input logic [2:0] eo);
    exp_t e;
    @(negedge clk);
    r_b = 1'b0; b_in_valid = 1'b1; b_in_bits = b; b_neg_en = n;
    e.bits = eb; e.first = ef; e.last = el; e.ovf = eo;
    q_b.push_back(e);
  endtask

  task automatic b_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      r_b = 1'b0; b_in_valid = 1'b0; b_in_bits = 3'($urandom); b_neg_en = 1'($urandom);
    end
  endtask

  logic [7:0] xw[3];
  logic [7:0] yw[3];
  logic       neg;
  logic [2:0] ib, eb, eo;

  initial begin
    n_tests = 0; n_fail = 0; mon_en = 1'b0;
    r_a = 1'b1; a_in_valid = 1'b1; a_in_bits = 2'b11; a_neg_en = 1'b1;
    r_b = 1'b1; b_in_valid = 1'b1; b_in_bits = 3'b111; b_neg_en = 1'b1;

    // reset dominates a valid beat: outputs must stay zero
    @(negedge clk);
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    b_in_valid = 1'b0;
    a_idle(2, 2'b00);

    // 1: lane0 = 6 negated -> 0,1,0,1 ; lane1 = 1 negated -> 1,1,1,1
    a_beat(2'b10, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00);
    a_beat(2'b01, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00);
    a_beat(2'b01, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00);
    a_beat(2'b00, 1'b1, 2'b11, 1'b0, 1'b1, 2'b00);

    // 2: lane0 = -8 negated -> unchanged + ovf ; lane1 = 0 -> 0, no ovf (back-to-back)
    a_beat(2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00);
    a_beat(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
    a_beat(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
    a_beat(2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 2'b01);
    a_idle(1, 2'b00);

    // 3: pass with neg_en raised mid-word (lane0 = 5, lane1 = 2), then negated word
    a_beat(2'b01, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00);
    a_beat(2'b10, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00);
    a_beat(2'b01, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00);
    a_beat(2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00);
    a_beat(2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00);
    a_beat(2'b10, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00);
    a_beat(2'b01, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00);
    a_beat(2'b00, 1'b0, 2'b11, 1'b0, 1'b1, 2'b00);
    a_idle(2, 2'b00);

    // 4: lane0 = 3 negated with a 3-cycle gap after bit 1 -> 1,0,1,1
    a_beat(2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00);
    a_beat(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
    a_idle(3, 2'b11);
    a_beat(2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00);
    a_beat(2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00);
    a_idle(1, 2'b00);

    // 5: two beats of 7, reset (with a valid beat present), then 1 negated -> 1,1,1,1
    a_beat(2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00);
    a_beat(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    r_a = 1'b1; a_in_valid = 1'b1; a_in_bits = 2'b11; a_neg_en = 1'b1;
    a_beat(2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00);
    a_beat(2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00);
    a_beat(2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00);
    a_beat(2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00);
    a_idle(3, 2'b00);

    // 6: 200 random words on the 3-lane, 8-bit instance
    for (int w = 0; w < 200; w++) begin
      neg = 1'($urandom);
      for (int c = 0; c < 3; c++) begin
        case ($urandom_range(0, 9))
          0:       xw[c] = 8'h80;
          1:       xw[c] = 8'h00;
          default: xw[c] = 8'($urandom);
        endcase
        yw[c] = neg ? (8'd0 - xw[c]) : xw[c];
      end
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 3) == 0) b_idle($urandom_range(1, 3));
        for (int c = 0; c < 3; c++) begin
          ib[c] = xw[c][i];
          eb[c] = yw[c][i];
          eo[c] = (i == 7) && neg && (xw[c] == 8'h80);
        end
        b_beat(ib, (i == 0) ? neg : 1'($urandom), eb, (i == 0), (i == 7), eo);
      end
    end
    b_idle(4);
    a_idle(1, 2'b00);

    chk("a_queue_drained", q_a.size(), 32'd0);
    chk("b_queue_drained", q_b.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
